// File: rtl/axil_alu_regs.sv
// AXI4-Lite register file fronting a small multi-cycle ALU (add/sub/logic/shift,
// iterative shift-add multiply) with start/busy/done status.
module axil_alu_regs #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready
);
    localparam int LSB = $clog2(DATA_WIDTH / 8);
    localparam int SHW = $clog2(DATA_WIDTH);
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    typedef enum logic [1:0] {A_IDLE, A_BUSY, A_DONE} a_state_t;

    w_state_t w_state_reg, w_state_next;
    r_state_t r_state_reg, r_state_next;
    a_state_t a_state_reg, a_state_next;

    logic                  awready_reg, awready_next, wready_reg, wready_next;
    logic                  aw_held_reg, aw_held_next, w_held_reg, w_held_next;
    logic [2:0]            awidx_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic                  bvalid_reg, bvalid_next;
    logic [1:0]            bresp_reg, bresp_next;
    logic                  arready_reg, arready_next, rvalid_reg, rvalid_next;
    logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
    logic [1:0]            rresp_reg, rresp_next;

    logic [DATA_WIDTH-1:0] op1_reg, op2_reg, result_reg;
    logic [3:0]            opcode_reg, opc_lat_reg;
    logic [DATA_WIDTH-1:0] a_reg, b_reg, acc_reg;
    logic [SHW-1:0]        cnt_reg;
    logic                  done_reg, err_reg;

    logic                  aw_hs, w_hs, ar_hs, commit, wr_en, start, alu_busy, alu_finish;
    logic [2:0]            wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0] wr_data, rd_val, alu_out, mul_step;
    logic [1:0]            wr_resp, rd_resp;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^{awaddr, araddr};

    assign aw_hs   = awvalid && awready_reg;
    assign w_hs    = wvalid && wready_reg;
    assign ar_hs   = arvalid && arready_reg;
    assign wr_idx  = aw_held_reg ? awidx_reg : awaddr[LSB+2:LSB];
    assign wr_data = w_held_reg ? wdata_reg : wdata;
    assign rd_idx  = araddr[LSB+2:LSB];
    assign commit  = (w_state_reg == W_IDLE) && (aw_held_reg || aw_hs) && (w_held_reg || w_hs);
    assign alu_busy = (a_state_reg == A_BUSY);
    assign wr_en   = commit && (wr_resp == OKAY);
    assign start   = wr_en && (wr_idx == 3'd3) && wr_data[0];

    always_comb begin
        case (wr_idx)
            3'd0, 3'd1, 3'd2, 3'd3: wr_resp = alu_busy ? SLVERR : OKAY;
            3'd4, 3'd5:             wr_resp = SLVERR;
            default:                wr_resp = DECERR;
        endcase
    end

    // AW and W are captured independently; the commit fires on the later of the two.
    always_comb begin
        w_state_next = w_state_reg;
        awready_next = awready_reg;
        wready_next  = wready_reg;
        aw_held_next = aw_held_reg;
        w_held_next  = w_held_reg;
        bvalid_next  = bvalid_reg;
        bresp_next   = bresp_reg;
        case (w_state_reg)
            W_IDLE: begin
                if (commit) begin
                    w_state_next = W_RESP;
                    bvalid_next  = 1'b1;
                    bresp_next   = wr_resp;
                    aw_held_next = 1'b0;
                    w_held_next  = 1'b0;
                    awready_next = 1'b0;
                    wready_next  = 1'b0;
                end else begin
                    aw_held_next = aw_held_reg || aw_hs;
                    w_held_next  = w_held_reg || w_hs;
                    awready_next = !(aw_held_reg || aw_hs);
                    wready_next  = !(w_held_reg || w_hs);
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_state_next = W_IDLE;
                    bvalid_next  = 1'b0;
                    awready_next = 1'b1;
                    wready_next  = 1'b1;
                end
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        rd_val  = '0;
        rd_resp = OKAY;
        case (rd_idx)
            3'd0:    rd_val = op1_reg;
            3'd1:    rd_val = op2_reg;
            3'd2:    rd_val = DATA_WIDTH'(opcode_reg);
            3'd3:    rd_val = '0;
            3'd4:    rd_val = result_reg;
            3'd5:    rd_val = DATA_WIDTH'({err_reg, done_reg, alu_busy});
            default: rd_resp = DECERR;
        endcase
    end

    always_comb begin
        r_state_next = r_state_reg;
        arready_next = arready_reg;
        rvalid_next  = rvalid_reg;
        rdata_next   = rdata_reg;
        rresp_next   = rresp_reg;
        case (r_state_reg)
            R_IDLE: begin
                arready_next = !ar_hs;
                if (ar_hs) begin
                    r_state_next = R_DATA;
                    rvalid_next  = 1'b1;
                    rdata_next   = rd_val;
                    rresp_next   = rd_resp;
                end
            end
            R_DATA: begin
                if (rready) begin
                    r_state_next = R_IDLE;
                    rvalid_next  = 1'b0;
                    arready_next = 1'b1;
                end
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    assign mul_step   = acc_reg + (b_reg[0] ? a_reg : '0);
    assign alu_finish = (opc_lat_reg != 4'd7) || (cnt_reg == SHW'(DATA_WIDTH - 1));

    always_comb begin
        case (opc_lat_reg)
            4'd0:    alu_out = a_reg + b_reg;
            4'd1:    alu_out = a_reg - b_reg;
            4'd2:    alu_out = a_reg & b_reg;
            4'd3:    alu_out = a_reg | b_reg;
            4'd4:    alu_out = a_reg ^ b_reg;
            4'd5:    alu_out = a_reg << b_reg[SHW-1:0];
            4'd6:    alu_out = a_reg >> b_reg[SHW-1:0];
            4'd7:    alu_out = mul_step;
            default: alu_out = '0;
        endcase
    end

    always_comb begin
        a_state_next = a_state_reg;
        case (a_state_reg)
            A_IDLE:  if (start) a_state_next = A_BUSY;
            A_BUSY:  if (alu_finish) a_state_next = A_DONE;
            A_DONE:  a_state_next = start ? A_BUSY : A_IDLE;
            default: a_state_next = A_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state_reg <= W_IDLE;
            r_state_reg <= R_IDLE;
            a_state_reg <= A_IDLE;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            awidx_reg   <= '0;
            wdata_reg   <= '0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= OKAY;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rdata_reg   <= '0;
            rresp_reg   <= OKAY;
        end else begin
            w_state_reg <= w_state_next;
            r_state_reg <= r_state_next;
            a_state_reg <= a_state_next;
            awready_reg <= awready_next;
            wready_reg  <= wready_next;
            aw_held_reg <= aw_held_next;
            w_held_reg  <= w_held_next;
            if (aw_hs) awidx_reg <= awaddr[LSB+2:LSB];
            if (w_hs)  wdata_reg <= wdata;
            bvalid_reg  <= bvalid_next;
            bresp_reg   <= bresp_next;
            arready_reg <= arready_next;
            rvalid_reg  <= rvalid_next;
            rdata_reg   <= rdata_next;
            rresp_reg   <= rresp_next;
        end
    end

    // Register file plus ALU datapath; operands are latched at start so later
    // register writes cannot disturb an operation in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op1_reg     <= '0;
            op2_reg     <= '0;
            opcode_reg  <= '0;
            result_reg  <= '0;
            opc_lat_reg <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            if (wr_en) begin
                case (wr_idx)
                    3'd0:    op1_reg <= wr_data;
                    3'd1:    op2_reg <= wr_data;
                    3'd2:    opcode_reg <= wr_data[3:0];
                    default: ;
                endcase
            end
            if (start) begin
                a_reg       <= op1_reg;
                b_reg       <= op2_reg;
                opc_lat_reg <= opcode_reg;
                acc_reg     <= '0;
                cnt_reg     <= '0;
                done_reg    <= 1'b0;
                err_reg     <= 1'b0;
            end else if (alu_busy) begin
                if (opc_lat_reg == 4'd7) begin
                    acc_reg <= mul_step;
                    a_reg   <= a_reg << 1;
                    b_reg   <= b_reg >> 1;
                    cnt_reg <= cnt_reg + 1'b1;
                end
                if (alu_finish) begin
                    done_reg <= 1'b1;
                    if (opc_lat_reg[3]) err_reg <= 1'b1;
                    else                result_reg <= alu_out;
                end
            end
        end
    end

    assign awready = awready_reg;
    assign wready  = wready_reg;
    assign bvalid  = bvalid_reg;
    assign bresp   = bresp_reg;
    assign arready = arready_reg;
    assign rvalid  = rvalid_reg;
    assign rdata   = rdata_reg;
    assign rresp   = rresp_reg;
endmodule

// File: doc/axil_alu_regs.md
# axil_alu_regs

AXI4-Lite slave exposing an operand/opcode/result register file in front of a small multi-cycle ALU. It is the parametrised successor of the team's byte-wide calculator slave. It adds independent AW/W acceptance, a read channel, a start/busy/done protocol, and an iterative multiplier. It sits on the AXI-Lite interconnect as a memory-mapped compute peripheral.

## Interface
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 8, register and ALU width; legal values 8/16/32/64
- clk  in  1  clock, all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- awaddr / awvalid / awready  in/in/out  ADDR_WIDTH/1/1  write address channel
- wdata / wvalid / wready  in/in/out  DATA_WIDTH/1/1  write data channel (no wstrb, full-word writes)
- bresp / bvalid / bready  out/out/in  2/1/1  write response channel
- araddr / arvalid / arready  in/in/out  ADDR_WIDTH/1/1  read address channel
- rdata / rresp / rvalid / rready  out/out/out/in  DATA_WIDTH/2/1/1  read data channel

## Operation
- Register index = addr[LSB+2:LSB], LSB = log2(DATA_WIDTH/8); higher address bits ignored.
- Map: 0 OP1 RW; 1 OP2 RW; 2 OPCODE RW (bits[3:0] stored, upper bits read 0); 3 CTRL WO (bit0=1 starts, reads 0, OKAY); 4 RESULT RO; 5 STATUS RO {err,done,busy} in bits[2:0]; 6-7 unmapped.
- bresp: OKAY 00; SLVERR 10 for writes to RESULT/STATUS, and for writes to OP1/OP2/OPCODE/CTRL while busy (write ignored); DECERR 11 for index 6-7 (ignored). rresp: OKAY, DECERR with rdata=0 for 6-7.
- Write FSM: W_IDLE -> captures AW and/or W independently (either order or same cycle). Each ready drops once its beat is captured. When both are held -> commit, W_RESP, bvalid=1. bvalid held until bready. Then W_IDLE, both readies high again. One outstanding write.
- Read FSM: R_IDLE (arready=1) -> on arvalid, rdata/rresp registered, R_DATA (rvalid=1, arready=0). rvalid/rdata stable until rready, then R_IDLE.
- ALU FSM: A_IDLE -> start commit -> A_BUSY (busy=1, done=0, err=0) -> A_DONE writes RESULT, done=1 -> A_IDLE. done/err stay sticky until the next start.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (logical, amount OP2[log2(DATA_WIDTH)-1:0]), 7 MUL (low DATA_WIDTH bits, shift-add iterative). 8-15 illegal: err=1, RESULT unchanged.
- ADD/SUB wrap modulo 2^DATA_WIDTH, no carry flag.
- Operands latched at start; a start with CTRL bit0=0 is OKAY and has no effect.

## Timing
- Reset (async assert, sync release): awready, wready, arready, bvalid, rvalid = 0; bresp, rresp, rdata = 0; OP1, OP2, OPCODE, RESULT, STATUS = 0; all FSMs idle. Readies rise on the first edge after rstn deasserts.
- Reset asserted mid-operation aborts any multiply, response or read immediately. No response is issued for the interrupted transaction.
- Write latency: bvalid rises the cycle after the later of the AW/W handshakes. Register update is visible to a read accepted from the same cycle bvalid rises.
- Read latency: rvalid one cycle after the AR handshake. Simultaneous read and write commit to the same register returns the old value.
- Start commit at cycle T: busy=1 from T+1. Single-cycle ops and illegal opcodes: busy high for 1 cycle, then RESULT/done valid at T+2. MUL: busy for DATA_WIDTH cycles, RESULT/done valid at T+1+DATA_WIDTH.
- Back-pressure: bready/rready held low for any number of cycles stalls only that channel. The ALU continues.
- Writes and reads proceed concurrently. The ALU never blocks reads; STATUS is pollable while busy.

## Test plan
- DATA_WIDTH=8: write OP1=0x05, OP2=0x03, OPCODE=0, CTRL=1; poll STATUS -> 0x02 at T+2, RESULT=0x08, all bresp 00.
- SUB 0x03-0x05 -> RESULT=0xFE. MUL 0x13*0x0D -> RESULT=0xF7 exactly 9 cycles after start commit; STATUS=0x01 during the intervening reads.
- W beat 3 cycles before AW, then AW/W same cycle, with bready held low 5 cycles -> single bvalid, held with stable bresp, register written once.
- During MUL: write OP1 -> bresp 10, OP1 unchanged. Write RESULT -> 10. Read index 6 -> rresp 11, rdata 0. OPCODE=0x9 start -> STATUS=0x06, RESULT unchanged.
- rready low 4 cycles on RESULT read while a write to OP2 commits -> rdata stable, no second rvalid, OP2 updated.
- Assert rstn low mid-MUL and mid-write-response -> all outputs and registers 0 asynchronously. After release, ADD 0x80+0x80 -> RESULT=0x00.
